// File: rtl/apb_demux_tmo_if.sv
// APB bus bundle for apb_demux_tmo: upstream master side plus the shared/one-hot
// downstream slave side. The slave modport is the demux view, master is the environment view.
interface apb_demux_tmo_if #(
  parameter int N_SLV      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]       paddr_i;
  logic [DATA_WIDTH-1:0]       pwdata_i;
  logic                        pwrite_i;
  logic                        psel_i;
  logic                        penable_i;
  logic [DATA_WIDTH-1:0]       prdata_o;
  logic                        pready_o;
  logic                        pslverr_o;
  logic [ADDR_WIDTH-1:0]       paddr_o;
  logic [DATA_WIDTH-1:0]       pwdata_o;
  logic                        pwrite_o;
  logic [N_SLV-1:0]            psel_o;
  logic                        penable_o;
  logic [N_SLV*DATA_WIDTH-1:0] prdata_i;
  logic [N_SLV-1:0]            pready_i;
  logic [N_SLV-1:0]            pslverr_i;

  modport slave (
    input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
    output prdata_o, pready_o, pslverr_o,
    output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport master (
    output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
    input  prdata_o, pready_o, pslverr_o,
    input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/apb_demux_tmo.sv
// APB 1-to-N demultiplexer with registered request path, decode-error response
// and a per-transfer watchdog so a hung or unmapped slave never stalls the master.
module apb_demux_tmo #(
  parameter int N_SLV          = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [N_SLV*ADDR_WIDTH-1:0] START_ADDR =
    {32'h1A10_3000, 32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000},
  parameter logic [N_SLV*ADDR_WIDTH-1:0] END_ADDR =
    {32'h1A10_4000, 32'h1A10_3000, 32'h1A10_2000, 32'h1A10_1000},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  apb_demux_tmo_if.slave        bus,
  output logic                  err_o,
  output logic [1:0]            err_cause_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o
);
  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  err_q, err_d;
  logic [1:0]            err_cause_q, err_cause_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic                  dec_hit_s;
  logic [IDX_W-1:0]      dec_idx_s;
  logic                  sel_ready_s;
  logic                  tmo_hit_s;
  logic [N_SLV-1:0]      psel_s;
  logic                  fwd_s;

  // Decode runs on the captured address; scanning downwards lets the lowest index win.
  always_comb begin
    dec_hit_s = 1'b0;
    dec_idx_s = '0;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if ((paddr_q >= START_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (paddr_q <  END_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        dec_hit_s = 1'b1;
        dec_idx_s = IDX_W'(k);
      end else begin
        dec_hit_s = dec_hit_s;
      end
    end
  end

  always_comb begin
    sel_ready_s = bus.pready_i[dec_idx_s];
    tmo_hit_s   = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT_CYCLES));
    fwd_s       = (state_q == ACCESS) && bus.psel_i;
  end

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    cnt_d       = cnt_q;
    prdata_d    = prdata_q;
    pslverr_d   = pslverr_q;
    err_d       = 1'b0;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.psel_i) begin
          paddr_d  = bus.paddr_i;
          pwdata_d = bus.pwdata_i;
          pwrite_d = bus.pwrite_i;
          cnt_d    = '0;
          state_d  = SETUP;
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP: begin
        if (dec_hit_s) begin
          state_d = ACCESS;
        end else begin
          prdata_d    = '0;
          pslverr_d   = 1'b1;
          err_d       = 1'b1;
          err_cause_d = 2'b01;
          err_addr_d  = paddr_q;
          state_d     = bus.psel_i ? RESP : IDLE;
        end
      end
      ACCESS, DRAIN: begin
        if (sel_ready_s) begin
          prdata_d  = bus.prdata_i[int'(dec_idx_s)*DATA_WIDTH +: DATA_WIDTH];
          pslverr_d = bus.pslverr_i[dec_idx_s];
          state_d   = fwd_s ? RESP : IDLE;
        end else if (tmo_hit_s) begin
          prdata_d    = '0;
          pslverr_d   = 1'b1;
          err_d       = 1'b1;
          err_cause_d = 2'b10;
          err_addr_d  = paddr_q;
          state_d     = fwd_s ? RESP : IDLE;
        end else begin
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          // Upstream gave up mid-access: keep the slave transfer alive but drop its result.
          state_d = ((state_q == ACCESS) && !bus.psel_i) ? DRAIN : state_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      cnt_q       <= '0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      err_q       <= 1'b0;
      err_cause_q <= 2'b00;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      cnt_q       <= cnt_d;
      prdata_q    <= prdata_d;
      pslverr_q   <= pslverr_d;
      err_q       <= err_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Downstream strobes come only from flops, never from the upstream inputs.
  always_comb begin
    psel_s = '0;
    if (((state_q == SETUP) || (state_q == ACCESS) || (state_q == DRAIN)) && dec_hit_s) begin
      psel_s[dec_idx_s] = 1'b1;
    end else begin
      psel_s = '0;
    end
  end

  assign bus.psel_o    = psel_s;
  assign bus.penable_o = (state_q == ACCESS) || (state_q == DRAIN);
  assign bus.paddr_o   = paddr_q;
  assign bus.pwdata_o  = pwdata_q;
  assign bus.pwrite_o  = pwrite_q;
  assign bus.pready_o  = (state_q == RESP);
  assign bus.prdata_o  = (state_q == RESP) ? prdata_q : '0;
  assign bus.pslverr_o = (state_q == RESP) ? pslverr_q : 1'b0;
  assign err_o         = err_q;
  assign err_cause_o   = err_cause_q;
  assign err_addr_o    = err_addr_q;
endmodule

// File: tb/tb_apb_demux_tmo.sv
// Bench for apb_demux_tmo: a per-cycle expected timeline is built from the address
// map and slave wait counts, and every output is compared against it each cycle.
module tb_apb_demux_tmo;
  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 8;
  localparam int MAXC = 512;
  localparam logic [31:0] RULE_LO [N] = '{32'h1A10_0000, 32'h1A10_1000, 32'h1A10_2000, 32'h1A10_3000};
  localparam logic [31:0] RULE_HI [N] = '{32'h1A10_1000, 32'h1A10_2000, 32'h1A10_3000, 32'h1A10_4000};

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  apb_demux_tmo_if #(.N_SLV(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic          err_o;
  logic [1:0]    err_cause_o;
  logic [AW-1:0] err_addr_o;

  apb_demux_tmo #(.N_SLV(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus),
    .err_o(err_o), .err_cause_o(err_cause_o), .err_addr_o(err_addr_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [N-1:0] e_psel [MAXC];
  bit           e_pen [MAXC], e_rdy [MAXC], e_slverr [MAXC], e_err [MAXC], e_wr [MAXC];
  logic [31:0]  e_rdata [MAXC], e_addr [MAXC], e_wdata [MAXC], e_eaddr [MAXC];
  logic [1:0]   e_cause [MAXC];

  int          swait [N];
  logic [31:0] sdata [N];
  bit          serr  [N];
  int          acnt  [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int mdl_decode(input logic [31:0] a);
    for (int k = 0; k < N; k++) begin
      if (a >= RULE_LO[k] && a < RULE_HI[k]) return k;
    end
    return -1;
  endfunction

  task automatic clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      e_psel[c] = '0; e_pen[c] = 1'b0; e_rdy[c] = 1'b0; e_slverr[c] = 1'b0;
      e_err[c] = 1'b0; e_wr[c] = 1'b0; e_rdata[c] = '0; e_addr[c] = '0;
      e_wdata[c] = '0; e_eaddr[c] = '0; e_cause[c] = 2'b00;
    end
  endtask

  task automatic sticky(input int c0, input logic [1:0] cause, input logic [31:0] a);
    for (int c = c0; c < MAXC; c++) begin
      e_cause[c] = cause;
      e_eaddr[c] = a;
    end
  endtask

  // One upstream transfer; drop>0 releases psel_i at cycle s+drop without waiting for pready_o.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input bit wr,
                      input int drop, output int resp);
    int s, k, w, last, n;
    bit tmo;
    s = cyc;
    k = mdl_decode(a);
    if (k < 0) begin
      resp = s + 2;
      e_rdy[resp] = 1'b1; e_slverr[resp] = 1'b1; e_rdata[resp] = '0;
      e_err[resp] = 1'b1;
      sticky(resp, 2'b01, a);
    end else begin
      w    = swait[k];
      tmo  = (w >= TMO);
      last = tmo ? s + 1 + TMO : s + 2 + w;
      for (int c = s + 1; c <= last; c++) begin
        e_psel[c] = '0; e_psel[c][k] = 1'b1;
        e_pen[c] = (c > s + 1);
        e_addr[c] = a; e_wdata[c] = wd; e_wr[c] = wr;
      end
      resp = last + 1;
      if (tmo) begin
        if (drop == 0) begin
          e_rdy[resp] = 1'b1; e_slverr[resp] = 1'b1; e_rdata[resp] = '0;
        end
        e_err[resp] = 1'b1;
        sticky(resp, 2'b10, a);
      end else if (drop == 0) begin
        e_rdy[resp] = 1'b1; e_slverr[resp] = serr[k]; e_rdata[resp] = sdata[k];
      end
    end
    bus.paddr_i = a; bus.pwdata_i = wd; bus.pwrite_i = wr;
    bus.psel_i = 1'b1; bus.penable_i = 1'b0;
    @(posedge clk); #1;
    bus.penable_i = 1'b1;
    if (drop == 0) begin
      n = 0;
      while (!bus.pready_o && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("resp_cycle", 64'(cyc), 64'(resp));
      @(posedge clk); #1;
      bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    end else begin
      while (cyc < s + drop) begin
        @(posedge clk); #1;
      end
      bus.psel_i = 1'b0; bus.penable_i = 1'b0;
      while (cyc <= resp) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Downstream slaves: slave k raises pready on its (swait[k]+1)-th access cycle.
  initial begin
    logic [N-1:0]    rdy_v, err_v;
    logic [N*DW-1:0] dat_v;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (bus.psel_o[k] && bus.penable_o) acnt[k]++;
        else acnt[k] = 0;
        rdy_v[k] = (acnt[k] == swait[k] + 1);
        err_v[k] = serr[k];
        dat_v[k*DW +: DW] = sdata[k];
      end
      bus.pready_i = rdy_v; bus.pslverr_i = err_v; bus.prdata_i = dat_v;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && cyc < MAXC) begin
        check("psel_o", 64'(bus.psel_o), 64'(e_psel[cyc]));
        check("penable_o", 64'(bus.penable_o), 64'(e_pen[cyc]));
        check("pready_o", 64'(bus.pready_o), 64'(e_rdy[cyc]));
        check("prdata_o", 64'(bus.prdata_o), 64'(e_rdata[cyc]));
        check("pslverr_o", 64'(bus.pslverr_o), 64'(e_slverr[cyc]));
        check("err_o", 64'(err_o), 64'(e_err[cyc]));
        check("err_cause_o", 64'(err_cause_o), 64'(e_cause[cyc]));
        check("err_addr_o", 64'(err_addr_o), 64'(e_eaddr[cyc]));
        if (e_psel[cyc] != '0) begin
          check("paddr_o", 64'(bus.paddr_o), 64'(e_addr[cyc]));
          check("pwdata_o", 64'(bus.pwdata_o), 64'(e_wdata[cyc]));
          check("pwrite_o", 64'(bus.pwrite_o), 64'(e_wr[cyc]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s0, r, n;
    bus.paddr_i = '0; bus.pwdata_i = '0; bus.pwrite_i = 1'b0;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    bus.prdata_i = '0; bus.pready_i = '0; bus.pslverr_i = '0;
    for (int k = 0; k < N; k++) begin
      swait[k] = 0; sdata[k] = 32'hA000_0000 + 32'(k); serr[k] = 1'b0; acnt[k] = 0;
    end
    clear_from(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_psel", 64'(bus.psel_o), 64'h0);
    check("rst_pready", 64'(bus.pready_o), 64'h0);
    check("rst_err_cause", 64'(err_cause_o), 64'h0);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Zero-wait write to slave 1.
    sdata[1] = 32'h0; s0 = cyc;
    xfer(32'h1A10_1004, 32'hCAFE_F00D, 1'b1, 0, r);
    check("pin_wr_lat", 64'(r - s0), 64'd3);
    check("pin_wr_psel", 64'(e_psel[s0+1]), 64'b0010);
    check("pin_wr_pen", 64'(e_pen[s0+2]), 64'd1);

    // Slave 3 with 5 wait states and pslverr.
    swait[3] = 5; sdata[3] = 32'h1234_5678; serr[3] = 1'b1; s0 = cyc;
    xfer(32'h1A10_3010, 32'h0, 1'b0, 0, r);
    check("pin_rd3_lat", 64'(r - s0), 64'd8);
    check("pin_rd3_data", 64'(e_rdata[r]), 64'h1234_5678);
    check("pin_rd3_err", 64'(e_err[r]), 64'd0);

    // Unmapped address.
    s0 = cyc;
    xfer(32'h2000_0000, 32'h0, 1'b0, 0, r);
    check("pin_miss_lat", 64'(r - s0), 64'd2);
    check("miss_cause", 64'(err_cause_o), 64'h1);
    check("miss_addr", 64'(err_addr_o), 64'h2000_0000);

    // Slave 0 never ready: watchdog.
    swait[0] = 1000; s0 = cyc;
    xfer(32'h1A10_0040, 32'h0, 1'b0, 0, r);
    check("pin_tmo_lat", 64'(r - s0), 64'd10);
    check("tmo_cause", 64'(err_cause_o), 64'h2);
    swait[0] = 0;
    swait[2] = 2; sdata[2] = 32'h55AA_33CC;
    xfer(32'h1A10_2008, 32'h0, 1'b0, 0, r);

    // Upstream abandons an access to slave 2.
    swait[2] = 3;
    xfer(32'h1A10_2100, 32'h0BAD_0BAD, 1'b1, 3, r);
    xfer(32'h1A10_1FFC, 32'h0, 1'b0, 0, r);
    xfer(32'h1A10_4000, 32'h0, 1'b0, 0, r);
    check("edge_miss_cause", 64'(err_cause_o), 64'h1);

    // Asynchronous reset in the middle of an access.
    chk_en = 1'b0;
    swait[2] = 5;
    bus.paddr_i = 32'h1A10_2000; bus.pwrite_i = 1'b0; bus.psel_i = 1'b1; bus.penable_i = 1'b0;
    n = 0;
    while (!bus.penable_o && n < 10) begin
      @(posedge clk); #1;
      bus.penable_i = 1'b1;
      n++;
    end
    check("rst_reach_access", 64'(bus.penable_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_psel", 64'(bus.psel_o), 64'h0);
    check("arst_penable", 64'(bus.penable_o), 64'h0);
    check("arst_pready", 64'(bus.pready_o), 64'h0);
    check("arst_err_cause", 64'(err_cause_o), 64'h0);
    check("arst_err_addr", 64'(err_addr_o), 64'h0);
    check("arst_paddr", 64'(bus.paddr_o), 64'h0);
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    clear_from(cyc);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    sdata[0] = 32'h0F0F_1234; s0 = cyc;
    xfer(32'h1A10_0000, 32'h0, 1'b0, 0, r);
    check("pin_post_rst_lat", 64'(r - s0), 64'd3);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
